spi_dev_reg_bridge: RTL and testbench
=====================================

Name: spi_dev_reg_bridge

Overview:
SPI target (mode 0, single-lane) that turns SPI frames from an external host into register-bus transactions on the SoC side. It is the responder counterpart of the SPI host the SoC already drives toward the SD card. The block lets an off-board controller read and write SoC registers for bring-up and debug. SCK, CSB and SDI are oversampled in the system clock domain, so there is no second clock.

Parameters:
AddrWidth, 32, width of the register address shifted in after the command byte
DataWidth, 32, register data width; fixed at 32, wstrb is all-ones
SyncStages, 2, synchronizer depth on spi_sck_i, spi_csb_i and spi_sd_i
DummyCycles, 8, SCK cycles between the last address bit and the first read-out bit

Ports:
clk_i  in  1  system clock; must be at least 8x the SCK frequency
rst_i  in  1  reset, synchronous, active-high
spi_sck_i  in  1  SPI clock from the host; idles low
spi_csb_i  in  1  chip select, active low
spi_sd_i  in  1  MOSI
spi_sd_o  out  1  MISO
spi_sd_en_o  out  1  MISO output enable
reg_addr_o  out  AddrWidth  request address
reg_write_o  out  1  1 = write, 0 = read
reg_wdata_o  out  DataWidth  write data
reg_wstrb_o  out  DataWidth/8  write strobe, always all-ones
reg_valid_o  out  1  request valid
reg_ready_i  in  1  request accepted; response is valid in the same cycle
reg_rdata_i  in  DataWidth  read data
reg_error_i  in  1  bus error
busy_o  out  1  a frame is active or a request is outstanding
err_o  out  1  sticky error flag; cleared only by rst_i

Behaviour:
- Reset values: spi_sd_o=0, spi_sd_en_o=0, reg_valid_o=0, reg_write_o=0, reg_addr_o=0, reg_wdata_o=0, busy_o=0, err_o=0, FSM=IDLE. Synchronizer flops reset to SCK=0, CSB=1.
- Synchronized signals are edge-detected. MOSI is sampled on the SCK rising edge; MISO is updated on the SCK falling edge. All fields are shifted MSB first.
- MISO output lags the SCK fall at the pin by SyncStages+1 clk_i cycles.
- spi_sd_en_o equals NOT(synced CSB) AND (state in RSTAT or RDATA).
- FSM states and transitions:
  - IDLE: on CSB falling edge, go to CMD.
  - CMD: collect 8 bits. 0x01 selects write, then ADDR. 0x02 selects read, then ADDR. Any other value goes to DISCARD.
  - ADDR: collect AddrWidth bits. Write goes to WDATA. Read asserts reg_valid_o with reg_write_o=0 and goes to RDUMMY.
  - WDATA: collect 32 bits, then assert reg_valid_o with reg_write_o=1 and go to WAIT.
  - RDUMMY: count DummyCycles rising edges, then go to RSTAT.
  - RSTAT: shift out 8 status bits: {6'b0, timeout, error}. timeout=1 if the read handshake had not completed when RSTAT was entered.
  - RDATA: shift out 32 bits of captured rdata; the value is 0 on timeout. Then go to DISCARD.
  - WAIT: hold until the handshake completes, then go to DISCARD.
  - DISCARD: ignore SCK; on CSB rising edge, go to IDLE.
- Register-bus handshake:
  - valid and all request fields stay stable until valid && ready; valid deasserts the cycle after.
  - rdata and error are captured in the handshake cycle.
  - reg_error_i or a read timeout sets err_o.
- CSB rising edge in any state returns the shifter to IDLE. A partial command, address or data field is dropped with no bus request.
- An outstanding request is never withdrawn. valid stays high until ready, then the block goes to IDLE. A new frame is accepted only once no request is outstanding; any earlier CSB fall is treated as DISCARD.
- Bit counters are 6 bits wide and reset on every state entry; there is no wrap-around inside a field.
- An SCK edge and a CSB deassertion in the same cycle: CSB takes priority and the edge is ignored.
- Asserting rst_i mid-frame returns every output to its reset value on the next clock edge.
- busy_o = (state != IDLE) OR reg_valid_o.

Decomposition:
- spi_dev_pkg: command constants CmdWrite=8'h01 and CmdRead=8'h02, the state enum, and the status-byte bit positions.
- spi_dev_sync sub-module: the SyncStages synchronizer plus rise/fall detect for SCK and the CSB fall/rise detect. It outputs sck_rise, sck_fall, csb_fall, csb_rise, csb_sync and sdi_sync.

Test Plan:
- Write frame: cmd 0x01, addr 0x0300_0010, data 0xCAFE_F00D, SCK=clk/8 -> exactly one request with addr=0x0300_0010, write=1, wdata=0xCAFE_F00D, wstrb=0xF; err_o stays 0.
- Read frame with ready 2 cycles after valid and rdata 0x1234_5678 -> MISO carries status 0x00 then 0x1234_5678; spi_sd_en_o is high only during those 40 bits.
- Read where ready arrives 1000 cycles after valid and SCK=clk/8 -> status byte 0x02, data 0x0000_0000, err_o=1; valid holds until ready.
- CSB rises after 20 address bits -> no reg_valid_o pulse, FSM back in IDLE; the next full write frame succeeds.
- Invalid cmd 0x55 followed by 64 SCK cycles -> no request, spi_sd_en_o=0 throughout; reg_error_i=1 on a valid write -> err_o set and sticky.
- rst_i asserted in WDATA and in WAIT -> all outputs at reset values on the next clock; a following read returns correct data.

Source files
------------

// File: rtl/spi_dev_pkg.sv
// Shared definitions for the SPI target to register-bus bridge.
// Holds the command opcodes, the shifter FSM state encoding, the status-byte
// layout and a helper that assembles the status byte.
package spi_dev_pkg;

    localparam int         CmdWidth = 8;
    localparam logic [7:0] CmdWrite = 8'h01;
    localparam logic [7:0] CmdRead  = 8'h02;

    // Status byte shifted out ahead of read data: {6'b0, timeout, error}
    localparam int StatusWidth    = 8;
    localparam int StatErrorBit   = 0;
    localparam int StatTimeoutBit = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDUMMY,
        ST_RSTAT,
        ST_RDATA,
        ST_WAIT,
        ST_DISCARD
    } state_e;

    function automatic logic [StatusWidth-1:0] status_byte(input logic timeout,
                                                           input logic error);
        logic [StatusWidth-1:0] s;
        s                 = '0;
        s[StatTimeoutBit] = timeout;
        s[StatErrorBit]   = error;
        return s;
    endfunction

endpackage

// File: rtl/spi_dev_sync.sv
// Oversampling front end: brings SCK, CSB and MOSI into the clk domain and
// produces single-cycle edge strobes.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   sck_raw/csb_raw/sdi_raw  asynchronous SPI pins
//   sck_rise/sck_fall     one-cycle strobes on synchronized SCK edges
//   csb_fall/csb_rise     one-cycle strobes on synchronized CSB edges
//   csb_sync/sdi_sync     synchronized CSB and MOSI levels
// SyncStages must be at least 2.
module spi_dev_sync #(
    parameter int SyncStages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck_raw,
    input  logic csb_raw,
    input  logic sdi_raw,
    output logic sck_rise,
    output logic sck_fall,
    output logic csb_fall,
    output logic csb_rise,
    output logic csb_sync,
    output logic sdi_sync
);

    logic [SyncStages-1:0] sck_q;
    logic [SyncStages-1:0] csb_q;
    logic [SyncStages-1:0] sdi_q;
    logic                  sck_prev;
    logic                  csb_prev;

    // MOSI goes through the same depth as SCK so the sampled bit lines up
    // with the detected rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q    <= '0;
            csb_q    <= '1;
            sdi_q    <= '0;
            sck_prev <= 1'b0;
            csb_prev <= 1'b1;
        end else begin
            sck_q    <= {sck_q[SyncStages-2:0], sck_raw};
            csb_q    <= {csb_q[SyncStages-2:0], csb_raw};
            sdi_q    <= {sdi_q[SyncStages-2:0], sdi_raw};
            sck_prev <= sck_q[SyncStages-1];
            csb_prev <= csb_q[SyncStages-1];
        end
    end

    assign sck_rise = sck_q[SyncStages-1] & ~sck_prev;
    assign sck_fall = ~sck_q[SyncStages-1] & sck_prev;
    assign csb_fall = ~csb_q[SyncStages-1] & csb_prev;
    assign csb_rise = csb_q[SyncStages-1] & ~csb_prev;
    assign csb_sync = csb_q[SyncStages-1];
    assign sdi_sync = sdi_q[SyncStages-1];

endmodule

// File: rtl/spi_dev_reg_bridge.sv
// SPI mode-0 target that converts host frames into register-bus requests.
// Frame: 8-bit command (0x01 write, 0x02 read), AddrWidth address bits, then
// either 32 write-data bits, or DummyCycles dummy clocks followed by an 8-bit
// status byte and 32 read-data bits on MISO. All fields MSB first.
// Ports:
//   clk_i, rst_i                 system clock, synchronous active-high reset
//   spi_sck_i/csb_i/sd_i         SPI pins from the host (oversampled)
//   spi_sd_o, spi_sd_en_o        MISO and its output enable
//   reg_addr/write/wdata/wstrb/valid_o  register request
//   reg_ready_i/rdata_i/error_i  response, valid in the ready cycle
//   busy_o                       frame active or request outstanding
//   err_o                        sticky: bus error or read timeout
// Handshake: a request is presented with reg_valid_o=1 and all request fields
// held stable until the cycle where reg_valid_o && reg_ready_i; reg_valid_o
// drops the following cycle. A request is never withdrawn once raised.
module spi_dev_reg_bridge
    import spi_dev_pkg::*;
#(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int SyncStages  = 2,
    parameter int DummyCycles = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   spi_sck_i,
    input  logic                   spi_csb_i,
    input  logic                   spi_sd_i,
    output logic                   spi_sd_o,
    output logic                   spi_sd_en_o,
    output logic [AddrWidth-1:0]   reg_addr_o,
    output logic                   reg_write_o,
    output logic [DataWidth-1:0]   reg_wdata_o,
    output logic [DataWidth/8-1:0] reg_wstrb_o,
    output logic                   reg_valid_o,
    input  logic                   reg_ready_i,
    input  logic [DataWidth-1:0]   reg_rdata_i,
    input  logic                   reg_error_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int RxWidth = (AddrWidth > DataWidth) ? AddrWidth : DataWidth;
    localparam int TxWidth = StatusWidth + DataWidth;

    state_e               state_q, state_d;
    logic                 sck_rise, sck_fall, csb_fall, csb_rise, csb_sync, sdi_sync;
    logic [5:0]           bit_cnt_q, field_len;
    logic                 field_done;
    logic [RxWidth-1:0]   rx_q, rx_next;
    logic                 is_write_q;
    logic [TxWidth-1:0]   tx_q;
    logic                 sd_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 write_q;
    logic [DataWidth-1:0] wdata_q;
    logic                 valid_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 rsp_err_q;
    logic                 err_q;
    logic                 handshake;
    logic                 timeout;
    logic                 stat_err;
    logic [DataWidth-1:0] read_word;

    spi_dev_sync #(.SyncStages(SyncStages)) u_sync (
        .clk      (clk_i),
        .rst      (rst_i),
        .sck_raw  (spi_sck_i),
        .csb_raw  (spi_csb_i),
        .sdi_raw  (spi_sd_i),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .csb_fall (csb_fall),
        .csb_rise (csb_rise),
        .csb_sync (csb_sync),
        .sdi_sync (sdi_sync)
    );

    assign rx_next   = {rx_q[RxWidth-2:0], sdi_sync};
    assign handshake = valid_q & reg_ready_i;

    // Response as seen at the moment RSTAT is entered; a handshake landing in
    // that very cycle still counts as completed.
    assign timeout   = valid_q & ~reg_ready_i;
    assign stat_err  = timeout ? 1'b0 : (handshake ? reg_error_i : rsp_err_q);
    assign read_word = timeout ? '0 : (handshake ? reg_rdata_i : rdata_q);

    // Number of SCK rising edges that make up the current field (0 = none).
    always_comb begin
        field_len = 6'd0;
        case (state_q)
            ST_CMD:    field_len = 6'(CmdWidth);
            ST_ADDR:   field_len = 6'(AddrWidth);
            ST_WDATA:  field_len = 6'(DataWidth);
            ST_RDUMMY: field_len = 6'(DummyCycles);
            ST_RSTAT:  field_len = 6'(StatusWidth);
            ST_RDATA:  field_len = 6'(DataWidth);
            default:   field_len = 6'd0;
        endcase
    end

    // CSB deassertion masks a coincident SCK edge.
    assign field_done = sck_rise & ~csb_rise & (field_len != 6'd0) &
                        (bit_cnt_q == field_len - 6'd1);

    always_comb begin
        state_d = state_q;
        if (state_q != ST_IDLE && csb_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:
                    if (csb_fall) state_d = valid_q ? ST_DISCARD : ST_CMD;
                ST_CMD:
                    if (field_done) begin
                        if (rx_next[CmdWidth-1:0] == CmdWrite ||
                            rx_next[CmdWidth-1:0] == CmdRead)
                            state_d = ST_ADDR;
                        else
                            state_d = ST_DISCARD;
                    end
                ST_ADDR:   if (field_done) state_d = is_write_q ? ST_WDATA : ST_RDUMMY;
                ST_WDATA:  if (field_done) state_d = ST_WAIT;
                ST_RDUMMY: if (field_done) state_d = ST_RSTAT;
                ST_RSTAT:  if (field_done) state_d = ST_RDATA;
                ST_RDATA:  if (field_done) state_d = ST_DISCARD;
                ST_WAIT:   if (handshake || !valid_q) state_d = ST_DISCARD;
                default:   state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            is_write_q <= 1'b0;
            tx_q       <= '0;
            sd_q       <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            rsp_err_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q)
                bit_cnt_q <= '0;
            else if (sck_rise && field_len != 6'd0)
                bit_cnt_q <= bit_cnt_q + 6'd1;

            if (sck_rise && (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_WDATA))
                rx_q <= rx_next;

            if (handshake) begin
                valid_q   <= 1'b0;
                rdata_q   <= reg_rdata_i;
                rsp_err_q <= reg_error_i;
                if (reg_error_i) err_q <= 1'b1;
            end

            if (field_done) begin
                case (state_q)
                    ST_CMD: is_write_q <= (rx_next[CmdWidth-1:0] == CmdWrite);
                    ST_ADDR: begin
                        addr_q <= rx_next[AddrWidth-1:0];
                        if (!is_write_q) begin
                            write_q <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                    ST_WDATA: begin
                        wdata_q <= rx_next[DataWidth-1:0];
                        write_q <= 1'b1;
                        valid_q <= 1'b1;
                    end
                    ST_RDUMMY: begin
                        tx_q <= {status_byte(timeout, stat_err), read_word};
                        if (timeout) err_q <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // MISO changes on SCK fall so the host sees a stable bit at rise.
            if (sck_fall && !csb_rise && (state_q == ST_RSTAT || state_q == ST_RDATA)) begin
                sd_q <= tx_q[TxWidth-1];
                tx_q <= {tx_q[TxWidth-2:0], 1'b0};
            end
        end
    end

    assign spi_sd_o    = sd_q;
    assign spi_sd_en_o = ~csb_sync & (state_q == ST_RSTAT || state_q == ST_RDATA);
    assign reg_addr_o  = addr_q;
    assign reg_write_o = write_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = '1;
    assign reg_valid_o = valid_q;
    assign busy_o      = (state_q != ST_IDLE) | valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_spi_dev_reg_bridge.sv
// Testbench for spi_dev_reg_bridge: SPI host driver at SCK = clk/8, a
// register-bus responder with programmable latency, a table of directed
// frames, hand-written reset/outstanding sequences and randomized frames
// checked against a frame-level reference model.
module tb_spi_dev_reg_bridge;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int DUMMY    = 8;
    localparam int HALF     = 4;
    localparam int ReqW     = AW + 1 + DW + DW / 8;
    localparam int OutStart = 8 + AW + DUMMY;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i;
    logic            spi_sck_i, spi_csb_i, spi_sd_i;
    logic            spi_sd_o, spi_sd_en_o;
    logic [AW-1:0]   reg_addr_o;
    logic            reg_write_o;
    logic [DW-1:0]   reg_wdata_o;
    logic [DW/8-1:0] reg_wstrb_o;
    logic            reg_valid_o;
    logic            reg_ready_i;
    logic [DW-1:0]   reg_rdata_i;
    logic            reg_error_i;
    logic            busy_o, err_o;

    spi_dev_reg_bridge dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .spi_sck_i   (spi_sck_i),
        .spi_csb_i   (spi_csb_i),
        .spi_sd_i    (spi_sd_i),
        .spi_sd_o    (spi_sd_o),
        .spi_sd_en_o (spi_sd_en_o),
        .reg_addr_o  (reg_addr_o),
        .reg_write_o (reg_write_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wstrb_o (reg_wstrb_o),
        .reg_valid_o (reg_valid_o),
        .reg_ready_i (reg_ready_i),
        .reg_rdata_i (reg_rdata_i),
        .reg_error_i (reg_error_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard + bus responder ----------------
    logic [ReqW-1:0] exp_q[$];
    logic [ReqW-1:0] got_q[$];
    int              rsp_delay = 0;
    logic [DW-1:0]   rsp_rdata = '0;
    logic            rsp_error = 1'b0;
    int              wait_cnt  = 0;
    logic [ReqW-1:0] first_req;

    function automatic logic [ReqW-1:0] cur_req();
        return {reg_addr_o, reg_write_o, reg_write_o ? reg_wdata_o : 32'h0, reg_wstrb_o};
    endfunction

    initial begin
        reg_ready_i = 1'b0;
        reg_rdata_i = '0;
        reg_error_i = 1'b0;
        forever begin
            @(negedge clk);
            reg_ready_i = 1'b0;
            reg_rdata_i = '0;
            reg_error_i = 1'b0;
            if (reg_valid_o && !rst_i) begin
                if (wait_cnt == 0) first_req = cur_req();
                if (wait_cnt >= rsp_delay) begin
                    reg_ready_i = 1'b1;
                    reg_rdata_i = rsp_rdata;
                    reg_error_i = rsp_error;
                    check("req_stable", cur_req(), first_req);
                    got_q.push_back(cur_req());
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check_reqs(input string name);
        check({name, "_req_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({name, "_req"}, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- SPI host driver ----------------
    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csb_assert();
        spi_csb_i = 1'b0;
        clk_wait(HALF);
    endtask

    task automatic csb_release();
        clk_wait(HALF);
        spi_csb_i = 1'b1;
        clk_wait(2 * HALF);
    endtask

    // Bit i of the frame is mosi[127-i]; MISO and enable are sampled just
    // before the SCK rising edge, when the host would sample.
    task automatic shift_bits(input logic [127:0] mosi, input int n,
                              output logic [127:0] miso, output logic [127:0] en);
        miso = '0;
        en   = '0;
        for (int i = 0; i < n; i++) begin
            spi_sd_i = mosi[127-i];
            clk_wait(HALF);
            miso[127-i] = spi_sd_o;
            en[127-i]   = spi_sd_en_o;
            spi_sck_i   = 1'b1;
            clk_wait(HALF);
            spi_sck_i   = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                             input int n, output logic [127:0] miso, output logic [127:0] en);
        csb_assert();
        shift_bits({cmd, addr, data, 56'h0}, n, miso, en);
        csb_release();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (reg_valid_o && k < 3000) begin
            clk_wait(1);
            k++;
        end
        clk_wait(2);
        check({name, "_valid_cleared"}, reg_valid_o, 1'b0);
    endtask

    function automatic logic [127:0] out_window();
        logic [127:0] m;
        m = '0;
        for (int i = OutStart; i < OutStart + 40; i++) m[127-i] = 1'b1;
        return m;
    endfunction

    function automatic logic [ReqW-1:0] req_word(input logic [7:0] cmd, input logic [31:0] addr,
                                                 input logic [31:0] data);
        return (cmd == 8'h01) ? {addr, 1'b1, data, 4'hF} : {addr, 1'b0, 32'h0, 4'hF};
    endfunction

    task automatic check_reset_outputs(input string name);
        check(name, {spi_sd_o, spi_sd_en_o, reg_valid_o, reg_write_o, reg_addr_o,
                     reg_wdata_o, busy_o, err_o}, '0);
    endtask

    // ---------------- reference model (frame level) ----------------
    typedef struct {
        logic            req;
        logic [ReqW-1:0] word;
        logic [39:0]     out_bits;
        logic [127:0]    en_mask;
        logic            err_set;
    } exp_t;

    // A request exists only if the whole command+address (+data for writes)
    // was clocked in with a valid opcode. A read times out when the bus needs
    // longer than the dummy phase (DUMMY SCK periods) to answer.
    function automatic exp_t model(input logic [7:0] cmd, input logic [31:0] addr,
                                   input logic [31:0] data, input int n, input int delay,
                                   input logic rerr);
        exp_t e;
        logic to;
        e.req      = 1'b0;
        e.word     = '0;
        e.out_bits = '0;
        e.en_mask  = '0;
        e.err_set  = 1'b0;
        to = (delay >= DUMMY * 2 * HALF);
        if (cmd == 8'h01 && n >= 8 + AW + DW) begin
            e.req     = 1'b1;
            e.word    = {addr, 1'b1, data, 4'hF};
            e.err_set = rerr;
        end else if (cmd == 8'h02 && n >= 8 + AW) begin
            e.req      = 1'b1;
            e.word     = {addr, 1'b0, 32'h0, 4'hF};
            e.out_bits = to ? {8'h02, 32'h0} : {7'h0, rerr, data};
            e.err_set  = to | rerr;
            if (n >= OutStart + 40) e.en_mask = out_window();
        end
        return e;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        int          n;
        int          delay;
        logic        rsp_err;
        logic        exp_req;
        logic [39:0] exp_out;
        logic        exp_en;
        logic        exp_valid_end;
        logic        exp_err;
    } vec_t;

    localparam int NV = 9;
    vec_t vt[NV];

    logic [127:0] miso, en;
    logic         err_exp;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{"wr_basic",       8'h01, 32'h0300_0010, 32'hCAFE_F00D, 72,   0, 1'b0, 1'b1, 40'h0,            1'b0, 1'b0, 1'b0};
        vt[1] = '{"rd_basic",       8'h02, 32'h0000_0040, 32'h1234_5678, 88,   2, 1'b0, 1'b1, 40'h00_1234_5678, 1'b1, 1'b0, 1'b0};
        vt[2] = '{"trunc_addr",     8'h01, 32'h0300_0010, 32'hCAFE_F00D, 28,   0, 1'b0, 1'b0, 40'h0,            1'b0, 1'b0, 1'b0};
        vt[3] = '{"wr_after_trunc", 8'h01, 32'h1000_0004, 32'hA5A5_5A5A, 72,   5, 1'b0, 1'b1, 40'h0,            1'b0, 1'b0, 1'b0};
        vt[4] = '{"bad_cmd",        8'h55, 32'h0000_0000, 32'h0000_0000, 72,   0, 1'b0, 1'b0, 40'h0,            1'b0, 1'b0, 1'b0};
        vt[5] = '{"wr_bus_err",     8'h01, 32'h2000_0000, 32'h0BAD_BEEF, 72,   3, 1'b1, 1'b1, 40'h0,            1'b0, 1'b0, 1'b1};
        vt[6] = '{"rd_sticky",      8'h02, 32'h0000_0080, 32'h8765_4321, 88,  10, 1'b0, 1'b1, 40'h00_8765_4321, 1'b1, 1'b0, 1'b1};
        vt[7] = '{"rd_err",         8'h02, 32'h0000_0084, 32'hDEAD_BEEF, 88,   0, 1'b1, 1'b1, 40'h01_DEAD_BEEF, 1'b1, 1'b0, 1'b1};
        vt[8] = '{"rd_timeout",     8'h02, 32'h0000_0100, 32'h5555_5555, 88, 1000, 1'b0, 1'b1, 40'h02_0000_0000, 1'b1, 1'b1, 1'b1};

        rst_i     = 1'b1;
        spi_sck_i = 1'b0;
        spi_csb_i = 1'b1;
        spi_sd_i  = 1'b0;
        clk_wait(4);
        check_reset_outputs("reset_state");
        rst_i = 1'b0;
        clk_wait(4);

        for (int v = 0; v < NV; v++) begin
            rsp_delay = vt[v].delay;
            rsp_rdata = vt[v].data;
            rsp_error = vt[v].rsp_err;
            if (vt[v].exp_req) exp_q.push_back(req_word(vt[v].cmd, vt[v].addr, vt[v].data));
            run_frame(vt[v].cmd, vt[v].addr, vt[v].data, vt[v].n, miso, en);
            check({vt[v].name, "_valid_at_end"}, reg_valid_o, vt[v].exp_valid_end);
            wait_idle(vt[v].name);
            check_reqs(vt[v].name);
            check({vt[v].name, "_en"}, en, vt[v].exp_en ? out_window() : 128'h0);
            if (vt[v].exp_en) check({vt[v].name, "_miso"}, miso[79:40], vt[v].exp_out);
            check({vt[v].name, "_err"}, err_o, vt[v].exp_err);
            check({vt[v].name, "_busy"}, busy_o, 1'b0);
        end

        // New frame while a timed-out read is still outstanding is discarded.
        rsp_delay = 1500;
        rsp_rdata = 32'h1111_2222;
        rsp_error = 1'b0;
        exp_q.push_back({32'h0000_0200, 1'b0, 32'h0, 4'hF});
        run_frame(8'h02, 32'h0000_0200, 32'h0, 88, miso, en);
        check("outst_rd_status", miso[79:40], {8'h02, 32'h0});
        run_frame(8'h01, 32'h0000_0300, 32'h7777_8888, 72, miso, en);
        check("outst_wr_en", en, 128'h0);
        check("outst_valid_held", reg_valid_o, 1'b1);
        wait_idle("outst");
        check_reqs("outst");

        // Reset while in WDATA: everything back to reset, no request appears.
        rsp_delay = 0;
        csb_assert();
        shift_bits({8'h01, 32'h0400_0000, 32'hFFFF_FFFF, 56'h0}, 8 + AW + 10, miso, en);
        rst_i = 1'b1;
        clk_wait(1);
        check_reset_outputs("rst_in_wdata");
        spi_csb_i = 1'b1;
        clk_wait(3);
        rst_i = 1'b0;
        clk_wait(8);
        check_reqs("rst_in_wdata");

        // Reset while in WAIT with the request still outstanding.
        rsp_delay = 100000;
        csb_assert();
        shift_bits({8'h01, 32'h0500_0000, 32'h1234_ABCD, 56'h0}, 8 + AW + DW, miso, en);
        clk_wait(4);
        check("wait_valid_up", reg_valid_o, 1'b1);
        rst_i = 1'b1;
        clk_wait(1);
        check_reset_outputs("rst_in_wait");
        spi_csb_i = 1'b1;
        clk_wait(3);
        rst_i = 1'b0;
        clk_wait(8);
        check_reqs("rst_in_wait");
        err_exp = 1'b0;

        // Read after reset returns the correct data.
        rsp_delay = 1;
        rsp_rdata = 32'hFEED_0123;
        rsp_error = 1'b0;
        exp_q.push_back({32'h0600_0008, 1'b0, 32'h0, 4'hF});
        run_frame(8'h02, 32'h0600_0008, 32'h0, 88, miso, en);
        wait_idle("rd_after_rst");
        check_reqs("rd_after_rst");
        check("rd_after_rst_miso", miso[79:40], {8'h00, 32'hFEED_0123});
        check("rd_after_rst_err", err_o, 1'b0);

        // Randomized frames against the reference model.
        for (int r = 0; r < 16; r++) begin
            int          kind;
            int          n;
            logic [7:0]  cmd;
            logic [31:0] addr, data;
            exp_t        e;
            kind = $urandom_range(0, 4);
            addr = $urandom;
            data = $urandom;
            rsp_error = ($urandom_range(0, 5) == 0);
            rsp_delay = $urandom_range(0, 30);
            cmd = 8'h01;
            n   = 8 + AW + DW;
            case (kind)
                0: cmd = 8'h01;
                1: begin cmd = 8'h02; n = 88; end
                2: begin cmd = 8'h02; n = 88; rsp_delay = $urandom_range(150, 300); rsp_error = 1'b0; end
                3: begin
                    cmd = 8'($urandom_range(0, 255));
                    while (cmd == 8'h01 || cmd == 8'h02) cmd = 8'($urandom_range(0, 255));
                end
                default: begin
                    cmd = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
                    n   = (cmd == 8'h01) ? $urandom_range(1, 71) : $urandom_range(1, 39);
                end
            endcase
            rsp_rdata = data;
            e = model(cmd, addr, data, n, rsp_delay, rsp_error);
            if (e.req) exp_q.push_back(e.word);
            err_exp = err_exp | e.err_set;
            run_frame(cmd, addr, data, n, miso, en);
            wait_idle("rand");
            check_reqs("rand");
            check("rand_en", en, e.en_mask);
            if (e.en_mask != 128'h0) check("rand_miso", miso[79:40], e.out_bits);
            check("rand_err", err_o, err_exp);
            check("rand_busy", busy_o, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
